image_port_arbiter: RTL
=======================

# image_port_arbiter

Shares the single processor-side port of the dual-port image RAM between two requesters, for example the robot processor and a screen-clear/sprite engine. Each cycle it grants at most one access using round-robin priority, registers the winning access onto the RAM port, and tracks outstanding reads so each requester gets its own read data back. It sits between the requesters and the image RAM; the VGA port of the RAM is untouched.

## Interface
- RD_LAT, 1: image RAM read latency in clocks, measured from the registered address to valid `ram_dout`. Legal range 1–3.
- X_MAX, 160: frame width; legal x is 0..X_MAX-1.
- Y_MAX, 120: frame height; legal y is 0..Y_MAX-1.

- clk  in  1  single system clock; everything is on the rising edge.
- resetn  in  1  reset, synchronous and active-low.
- req[1:0]  in  2  access request, one bit per requester.
- we[1:0]  in  2  1 = write, 0 = read, per requester.
- x0, x1  in  8 each  pixel x coordinate.
- y0, y1  in  7 each  pixel y coordinate.
- wd0, wd1  in  3 each  write colour.
- gnt[1:0]  out  2  access accepted this cycle; combinational, one-hot or zero.
- rvalid[1:0]  out  2  read data valid for that requester.
- rdata  out  3  read colour, shared by both requesters and qualified by `rvalid`.
- ram_x  out  8  registered x address to the RAM.
- ram_y  out  7  registered y address to the RAM.
- ram_din  out  3  registered write data to the RAM.
- ram_wren  out  1  registered write enable to the RAM.
- ram_dout  in  3  RAM read data.

## Operation
**Request rules**
- Requester i holds `req[i]`, `we`, x, y and wd stable until it sees `gnt[i]` high at a clock edge.
- An access is accepted on the edge where `req[i] & gnt[i]` is high.
- Dropping `req` before the grant is allowed; nothing is issued.

**Arbitration**
- The priority pointer `last` (1 bit) names the most recently granted requester.
- If both requesters are asking, the one that is not `last` wins.
- If only one is asking, it wins regardless of `last`.
- `last` updates only on an accepted access.
- After reset, `last` = 1, so requester 0 wins the first contest.

**Issue**
- On acceptance, the next edge registers the winner's x, y and wd onto `ram_x`, `ram_y` and `ram_din`.
- On the same edge, `ram_wren` is loaded with 1 only if the access is a write and in range.
- In any cycle with no acceptance, `ram_wren` = 0 and the address/data registers hold their values.

**Range check**
- An access is out of range if x ≥ X_MAX or y ≥ Y_MAX.
- It is still granted and still advances `last`.
- An out-of-range write does not assert `ram_wren`.
- An out-of-range read still returns `rvalid`, with `rdata` = 0.

**Read tracking**
- Every accepted read pushes a tag (requester id, oob flag) into a shift pipeline of depth RD_LAT+1.
- When the tag reaches the end of the pipeline, `rvalid[id]` pulses for 1 cycle.
- `rdata` = oob ? 0 : `ram_dout`.
- Back-to-back reads, one per cycle, are fully pipelined with no bubbles.

**Reset**
- All outputs are 0: `gnt`, `rvalid`, `rdata`, `ram_x`, `ram_y`, `ram_din`, `ram_wren`.
- `last` = 1 and the tag pipeline is cleared.
- Reads in flight when reset asserts are discarded; no `rvalid` is produced for them.
- `gnt` is forced to 0 in every cycle that `resetn` = 0.

## Timing
- Throughput is 1 access per cycle in aggregate; no dead cycles between grants.
- Write latency: accepted at edge N, `ram_wren` is high during cycle N+1, and the RAM writes at edge N+2.
- Read latency: accepted at edge N, `rvalid` and `rdata` are valid during cycle N+1+RD_LAT, i.e. 2 cycles after acceptance when RD_LAT = 1.
- Read/write ordering: a read accepted in the cycle after a write to the same pixel returns the new colour. Port A of the RAM is read-after-write in order, and the arbiter issues accesses strictly in grant order.
- Fairness: with both requesters continuously asking, grants alternate 0,1,0,1. Worst-case wait is 1 cycle.

## Structure
- Shared package `image_pkg` holds:
  - X_W = 8, Y_W = 7, COLOR_W = 3;
  - X_MAX = 160, Y_MAX = 120;
  - typedef `pix_req_t` (we, x, y, wd);
  - typedef `rd_tag_t` (id, oob).
- Sub-module `rd_tag_pipe`: a parameterised-depth shift register of `rd_tag_t` with a valid bit per stage and synchronous clear.
- Arbitration, range check and issue registers stay in the top module.

## Test plan
- **Reset:** hold `resetn` = 0 for 3 cycles with `req` = 2'b11 → `gnt` = 0, `ram_wren` = 0, no `rvalid`. Release reset → first grant goes to requester 0.
- **Contention:** both requesters write continuously (requester 0 at (10,20) colour 3'b101, requester 1 at (11,20) colour 3'b010) for 6 cycles → `gnt` alternates 01,10,01,…; `ram_wren` is high for 6 consecutive cycles with the matching address and data.
- **Read routing:** requester 1 writes (5,5) colour 3'b110, then requester 0 reads (5,5) on the next accepted cycle → `rvalid[0]` pulses 2 cycles after the read is accepted with `rdata` = 3'b110; `rvalid[1]` stays 0.
- **Out of range:** requester 0 writes (160,0), then reads (0,120) → no `ram_wren` pulse for the write; the read returns `rvalid[0]` with `rdata` = 0.
- **Reset mid-read:** accept a read, then assert `resetn` = 0 on the next edge → no `rvalid` ever appears for that read. After release, a new read completes normally.
- **Pipelined reads:** 8 back-to-back reads from requester 1 at x = 0..7, y = 0 on a preloaded ramp image → 8 consecutive `rvalid[1]` pulses returning the ramp values in order.

Source files
------------

// File: rtl/image_pkg.sv
// rtl/image_pkg.sv - shared widths, frame limits and access/tag types for the image RAM port
package image_pkg;
    localparam int X_W     = 8;
    localparam int Y_W     = 7;
    localparam int COLOR_W = 3;
    localparam int X_MAX   = 160;
    localparam int Y_MAX   = 120;

    typedef struct packed {
        logic               we;
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] wd;
    } pix_req_t;

    typedef struct packed {
        logic id;
        logic oob;
    } rd_tag_t;
endpackage

// File: rtl/rd_tag_pipe.sv
// rtl/rd_tag_pipe.sv - fixed-depth shift pipeline of read tags, one valid bit per stage
module rd_tag_pipe
    import image_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    resetn,
    input  logic    push,
    input  rd_tag_t tag_in,
    output logic    out_valid,
    output rd_tag_t tag_out
);
    logic [DEPTH-1:0] vld;
    rd_tag_t          stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld <= '0;
            for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
        end else begin
            vld      <= {vld[DEPTH-2:0], push};
            stage[0] <= tag_in;
            for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign tag_out   = stage[DEPTH-1];
endmodule

// File: rtl/image_port_arbiter.sv
// rtl/image_port_arbiter.sv - round-robin arbiter sharing the image RAM processor port between two requesters
module image_port_arbiter
    import image_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int X_MAX  = image_pkg::X_MAX,
    parameter int Y_MAX  = image_pkg::Y_MAX
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [1:0]         req,
    input  logic [1:0]         we,
    input  logic [X_W-1:0]     x0,
    input  logic [X_W-1:0]     x1,
    input  logic [Y_W-1:0]     y0,
    input  logic [Y_W-1:0]     y1,
    input  logic [COLOR_W-1:0] wd0,
    input  logic [COLOR_W-1:0] wd1,
    output logic [1:0]         gnt,
    output logic [1:0]         rvalid,
    output logic [COLOR_W-1:0] rdata,
    output logic [X_W-1:0]     ram_x,
    output logic [Y_W-1:0]     ram_y,
    output logic [COLOR_W-1:0] ram_din,
    output logic               ram_wren,
    input  logic [COLOR_W-1:0] ram_dout
);
    localparam logic [X_W:0] X_LIM = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(Y_MAX);

    logic     last;
    logic     accept;
    logic     win;
    logic     oob;
    pix_req_t r0, r1, sel;
    logic     tag_valid;
    rd_tag_t  tag_in, tag_out;

    assign r0 = '{we: we[0], x: x0, y: y0, wd: wd0};
    assign r1 = '{we: we[1], x: x1, y: y1, wd: wd1};

    // Contention goes to whoever was not granted last; a lone requester always wins.
    always_comb begin
        gnt = 2'b00;
        if (resetn) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    assign accept = |gnt;
    assign win    = gnt[1];
    assign sel    = win ? r1 : r0;
    assign oob    = ({1'b0, sel.x} >= X_LIM) || ({1'b0, sel.y} >= Y_LIM);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last     <= 1'b1;
            ram_x    <= '0;
            ram_y    <= '0;
            ram_din  <= '0;
            ram_wren <= 1'b0;
        end else begin
            ram_wren <= accept & sel.we & ~oob;
            if (accept) begin
                last    <= win;
                ram_x   <= sel.x;
                ram_y   <= sel.y;
                ram_din <= sel.wd;
            end
        end
    end

    // Out-of-range reads still travel the pipe so the requester sees a (zero) response.
    assign tag_in = '{id: win, oob: oob};

    rd_tag_pipe #(.DEPTH(RD_LAT + 1)) u_tag_pipe (
        .clk       (clk),
        .resetn    (resetn),
        .push      (accept & ~sel.we),
        .tag_in    (tag_in),
        .out_valid (tag_valid),
        .tag_out   (tag_out)
    );

    assign rvalid[0] = tag_valid & ~tag_out.id;
    assign rvalid[1] = tag_valid &  tag_out.id;
    assign rdata     = (tag_valid && !tag_out.oob) ? ram_dout : '0;
endmodule
